ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
Bitstream loader for the configuration-chain flip-flops (ccff) of a logic tile such as the ble6 LUT6/FF/output-mux cell.
- Accepts configuration words from the host over a valid/ready interface.
- Serializes each word MSB-first onto ccff_head.
- Produces a shift enable that gates prog_clk to the chain through an external ICG, so the chain advances only when a valid bit is presented.
- Counts exactly CHAIN_LEN bits, then asserts cfg_done to release the fabric from configuration.

Parameters:
CHAIN_LEN, 66, number of ccff bits in the target chain (64 LUT6 + 2 output-mux bits).
WORD_W, 32, host configuration word width.
(derived localparams) CNT_W = $clog2(CHAIN_LEN+1); NWORDS = ceil(CHAIN_LEN/WORD_W).

Ports:
prog_clk  input  1  programming clock; all state on rising edge.
prog_reset  input  1  reset, synchronous, active-high.
start  input  1  one-cycle pulse that begins a load; ignored while busy.
cfg_word  input  WORD_W  configuration word; bit [WORD_W-1] is shifted first.
cfg_word_valid  input  1  cfg_word is valid.
cfg_word_ready  output  1  loader accepts cfg_word this cycle.
ccff_head  output  1  serial data into the chain head.
ccff_tail  input  1  serial data from the chain tail.
ccff_shift_en  output  1  chain clock enable for the external ICG.
busy  output  1  load or verify in progress.
cfg_done  output  1  configuration complete; drives the fabric cfg_done.
verify_err  output  1  readback CRC mismatch (sticky until next start).

Behaviour:
- Interface: one clock (prog_clk); reset is synchronous and active-high (prog_reset).
- Reset values: all outputs 0, state IDLE, counters 0, word buffer empty.
- States: IDLE, LOAD, VERIFY (only when the macro is defined), DONE.
- IDLE:
  - start=1 → LOAD next cycle; busy=1, cfg_done=0, verify_err=0, bits_left=CHAIN_LEN.
- LOAD:
  - cfg_word_ready=1 iff the buffer is empty and bits_left>0. Ready is registered-state-derived and has no combinational path from valid.
  - On valid&&ready: buffer loads cfg_word; buf_cnt=min(WORD_W, bits_left).
  - Each cycle with buf_cnt>0:
    - ccff_shift_en=1 and ccff_head=buffer MSB.
    - Buffer shifts left; buf_cnt and bits_left decrement.
  - Buffer empty: ccff_shift_en=0, ccff_head=0, so the chain holds.
  - This gives one bubble cycle per word. Minimum load = CHAIN_LEN + NWORDS cycles after start+1.
  - Final partial word: only the top (CHAIN_LEN mod WORD_W) bits are shifted; the rest are discarded.
  - Valid held with no ready: stall, no data loss.
  - When bits_left reaches 0 on the shift cycle → VERIFY if compiled, else DONE.
- DONE:
  - cfg_done=1 and busy=0, held until the next start or reset.
  - start in DONE → LOAD again, clearing cfg_done in that same cycle.
- Reset mid-LOAD or mid-VERIFY:
  - Immediate return to IDLE; shift_en drops in the reset cycle.
  - Chain content is undefined, and cfg_done stays 0.
- start while busy is ignored.
- A simultaneous start and reset resolves to reset.

Optional Feature:
Macro CCFF_CHAIN_LOADER_VERIFY_EN.
- Defined:
  - During LOAD, a serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates every shifted ccff_head bit.
  - VERIFY then runs exactly CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail, recirculating the chain. Chain content is restored after the pass.
  - A second CRC accumulates the ccff_tail bits.
  - At the end of VERIFY: CRCs equal → DONE with cfg_done=1. CRCs differ → DONE with cfg_done=0 and verify_err=1.
  - Latency is +CHAIN_LEN cycles.
- Undefined:
  - No VERIFY state and no CRC logic.
  - verify_err is tied 0; the port remains present.

Decomposition:
- Package ccff_chain_loader_pkg holds:
  - state enum (IDLE, LOAD, VERIFY, DONE);
  - CRC16_POLY, CRC16_INIT constants;
  - a function for ceil-division.
- Sub-module ccff_crc16_serial (clk, sync clear, bit_en, bit_in, crc out), instantiated twice under the macro.

Test Plan:
- Basic load, CHAIN_LEN=66, WORD_W=32, words 0xDEADBEEF, 0x01234567, 0xC0000000 → exactly 66 shift_en pulses. The 66-bit model shift register equals DEADBEEF_01234567 followed by bits 11. cfg_done rises the cycle after the last shift.
- Backpressure: valid deasserted for 10 cycles between words → shift_en=0 and ccff_head=0 during the gap. Final chain content is unchanged versus the no-gap load.
- Partial-word discard: the third word is 0xFFFFFFFF → only 2 bits are shifted, and the shift_en pulse count is 66, not 96.
- Reset at cycle 20 of LOAD → next cycle busy=0, cfg_done=0, ready=0, shift_en=0. A new start completes a clean load.
- start pulsed while busy → no effect. start in DONE → cfg_done falls the same cycle and a reload proceeds.
- With VERIFY_EN, chain model good → cfg_done=1 after 66 extra cycles and verify_err=0. With one chain bit forced flipped during VERIFY → verify_err=1 and cfg_done=0.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// rtl/ccff_chain_loader_pkg.sv - shared types, constants and helpers for the ccff chain loader
//
// Purpose : loader FSM state encoding, CRC-16-CCITT constants, a ceil-division
//           helper for derived sizes, and the single-bit CRC update step.
// Ports   : none (package).
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // One MSB-first serial step of CRC-16-CCITT.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// rtl/ccff_crc16_serial.sv - bit-serial CRC-16-CCITT accumulator
//
// Purpose : accumulates one bit per enabled cycle into a CRC-16-CCITT register.
// Ports   : clk     - clock, state on rising edge
//           clr     - synchronous clear to CRC16_INIT (wins over bit_en)
//           bit_en  - accumulate bit_in this cycle
//           bit_in  - serial data bit
//           crc     - current CRC value
module ccff_crc16_serial
  import ccff_chain_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC16_INIT;
    end else if (bit_en) begin
      crc_d = crc16_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serial bitstream loader for a tile configuration chain
//
// Purpose : takes configuration words over valid/ready, shifts them MSB-first
//           into the ccff chain with a gated-clock enable, counts exactly
//           CHAIN_LEN bits and then releases the fabric with cfg_done.
//           Optional readback verify (macro CCFF_CHAIN_LOADER_VERIFY_EN):
//           recirculates the chain once and compares CRCs of written and
//           read-back bits.
// Ports   : prog_clk, prog_reset (sync, active-high)
//           start                 - one-cycle load request, ignored while busy
//           cfg_word/_valid/_ready- host configuration word stream
//           ccff_head/ccff_tail   - chain serial in / serial out
//           ccff_shift_en         - enable for the external prog_clk ICG
//           busy, cfg_done, verify_err - status
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 66,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_word_valid,
  output logic              cfg_word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              cfg_done,
  output logic              verify_err
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS    = ceil_div(CHAIN_LEN, WORD_W);
  localparam int BUF_CNT_W = $clog2(WORD_W + 1);
  // Largest number of bits one word can contribute; fits both counters.
  localparam int WORD_CAP  = (WORD_W < CHAIN_LEN) ? WORD_W : CHAIN_LEN;

  state_e                 state_q,     state_d;
  logic [CNT_W-1:0]       bits_left_q, bits_left_d;
  logic [WORD_W-1:0]      buf_q,       buf_d;
  logic [BUF_CNT_W-1:0]   buf_cnt_q,   buf_cnt_d;
  logic                   cfg_done_q,  cfg_done_d;

  logic                   load_shift;
  logic                   accept;

  // Shifting and ready both come from registered state only, so the host
  // never sees a combinational valid->ready path.
  assign load_shift     = (state_q == LOAD) && (buf_cnt_q != '0);
  assign cfg_word_ready = (state_q == LOAD) && (buf_cnt_q == '0) && (bits_left_q != '0);
  assign accept         = cfg_word_valid && cfg_word_ready;
  assign busy           = (state_q == LOAD) || (state_q == VERIFY);
  assign cfg_done       = cfg_done_q;

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             verify_err_q, verify_err_d;
  logic             crc_clr;
  logic [15:0]      crc_load;
  logic [15:0]      crc_tail;
  logic             in_verify;

  assign in_verify     = (state_q == VERIFY);
  // During verify the chain feeds back on itself so its content survives.
  assign ccff_shift_en = load_shift || in_verify;
  assign ccff_head     = load_shift ? buf_q[WORD_W-1] : (in_verify ? ccff_tail : 1'b0);
  assign verify_err    = verify_err_q;

  ccff_crc16_serial u_crc_load (
    .clk    (prog_clk),
    .clr    (crc_clr),
    .bit_en (load_shift),
    .bit_in (buf_q[WORD_W-1]),
    .crc    (crc_load)
  );

  ccff_crc16_serial u_crc_tail (
    .clk    (prog_clk),
    .clr    (crc_clr),
    .bit_en (in_verify),
    .bit_in (ccff_tail),
    .crc    (crc_tail)
  );
`else
  logic unused_tail;

  assign unused_tail   = ccff_tail;
  assign ccff_shift_en = load_shift;
  assign ccff_head     = load_shift ? buf_q[WORD_W-1] : 1'b0;
  assign verify_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    cfg_done_d  = cfg_done_q;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    vcnt_d       = vcnt_q;
    verify_err_d = verify_err_q;
    crc_clr      = prog_reset;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          bits_left_d = CNT_W'(CHAIN_LEN);
          buf_cnt_d   = '0;
          cfg_done_d  = 1'b0;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
          verify_err_d = 1'b0;
          crc_clr      = 1'b1;
`endif
        end
      end

      LOAD: begin
        if (load_shift) begin
          buf_d       = {buf_q[WORD_W-2:0], 1'b0};
          buf_cnt_d   = buf_cnt_q - 1'b1;
          bits_left_d = bits_left_q - 1'b1;
          if (bits_left_q == CNT_W'(1)) begin
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
            state_d = VERIFY;
            vcnt_d  = CNT_W'(CHAIN_LEN);
`else
            state_d    = DONE;
            cfg_done_d = 1'b1;
`endif
          end
        end else if (accept) begin
          // The final word may carry more bits than the chain still needs;
          // the low surplus bits are simply never shifted out.
          buf_d = cfg_word;
          if (bits_left_q >= CNT_W'(WORD_CAP)) begin
            buf_cnt_d = BUF_CNT_W'(WORD_CAP);
          end else begin
            buf_cnt_d = BUF_CNT_W'(bits_left_q);
          end
        end
      end

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
      VERIFY: begin
        vcnt_d = vcnt_q - 1'b1;
        if (vcnt_q == CNT_W'(1)) begin
          state_d = DONE;
          // Fold the final tail bit in here rather than spending a cycle.
          if (crc_load == crc16_step(crc_tail, ccff_tail)) begin
            cfg_done_d = 1'b1;
          end else begin
            verify_err_d = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      vcnt_q       <= '0;
      verify_err_q <= 1'b0;
    end else begin
      vcnt_q       <= vcnt_d;
      verify_err_q <= verify_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 66;
  localparam int WORD_W    = 32;
  localparam int NWORDS    = 3;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LOAD_CYCLES = CHAIN_LEN + NWORDS + (VERIFY ? CHAIN_LEN : 0);

  logic              clk = 1'b0;
  logic              prog_reset;
  logic              start;
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_word_valid;
  logic              cfg_word_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              ccff_shift_en;
  logic              busy;
  logic              cfg_done;
  logic              verify_err;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 tail_flip = 1'b0;
  int                   shift_cnt = 0;
  int                   busy_cnt = 0;
  int                   checks = 0;
  int                   errors = 0;

  always #5 clk = ~clk;

  ccff_chain_loader dut (
    .prog_clk       (clk),
    .prog_reset     (prog_reset),
    .start          (start),
    .cfg_word       (cfg_word),
    .cfg_word_valid (cfg_word_valid),
    .cfg_word_ready (cfg_word_ready),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .ccff_shift_en  (ccff_shift_en),
    .busy           (busy),
    .cfg_done       (cfg_done),
    .verify_err     (verify_err)
  );

  // Chain of flip-flops clocked through the ICG: head enters at bit 0,
  // the first bit written ends up at the top and appears at the tail.
  assign ccff_tail = chain[CHAIN_LEN-1] ^ tail_flip;

  always @(posedge clk) begin
    if (ccff_shift_en) begin
      chain     <= {chain[CHAIN_LEN-2:0], ccff_head};
      shift_cnt <= shift_cnt + 1;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_chain(input string nm, input logic [CHAIN_LEN-1:0] req);
    checks++;
    if (chain !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, chain, req, $time);
    end
  endtask

  // Transaction-level reference: a phase, the number of chain bits still owed,
  // a queue of bits waiting in the word buffer, and the lists of bits written
  // and read back.
  int  m_phase = 0;  // 0 idle, 1 load, 2 verify, 3 done
  int  m_left  = 0;
  int  m_vcnt  = 0;
  bit  m_q[$];
  bit  m_sh[$];
  bit  m_tl[$];
  bit  m_done  = 1'b0;
  bit  m_err   = 1'b0;
  bit  m_init  = 1'b0;

  always @(posedge clk) begin
    bit e_rdy;
    bit same;
    int take;
    e_rdy = (m_phase == 1) && (m_q.size() == 0) && (m_left > 0);
    if (prog_reset) begin
      m_init  = 1'b1;
      m_phase = 0;
      m_left  = 0;
      m_q.delete();
      m_done  = 1'b0;
      m_err   = 1'b0;
    end else if (m_init) begin
      case (m_phase)
        0, 3: if (start) begin
          m_phase = 1;
          m_left  = CHAIN_LEN;
          m_done  = 1'b0;
          m_err   = 1'b0;
          m_q.delete();
          m_sh.delete();
          m_tl.delete();
        end
        1: if (m_q.size() > 0) begin
          m_sh.push_back(m_q.pop_front());
          m_left--;
          if (m_left == 0) begin
            if (VERIFY) begin
              m_phase = 2;
              m_vcnt  = CHAIN_LEN;
            end else begin
              m_phase = 3;
              m_done  = 1'b1;
            end
          end
        end else if (cfg_word_valid && e_rdy) begin
          take = (m_left < WORD_W) ? m_left : WORD_W;
          for (int k = 0; k < take; k++) m_q.push_back(cfg_word[WORD_W-1-k]);
        end
        2: begin
          m_tl.push_back(ccff_tail);
          m_vcnt--;
          if (m_vcnt == 0) begin
            m_phase = 3;
            same = (m_tl.size() == m_sh.size());
            for (int k = 0; k < m_sh.size() && k < m_tl.size(); k++)
              if (m_tl[k] != m_sh[k]) same = 1'b0;
            if (same) m_done = 1'b1;
            else m_err = 1'b1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    bit e_sl;
    if (m_init) begin
      e_sl = (m_phase == 1) && (m_q.size() > 0);
      chk("busy", busy, (m_phase == 1) || (m_phase == 2));
      chk("ready", cfg_word_ready, (m_phase == 1) && (m_q.size() == 0) && (m_left > 0));
      chk("shift_en", ccff_shift_en, e_sl || (m_phase == 2));
      chk("head", ccff_head, e_sl ? m_q[0] : ((m_phase == 2) ? ccff_tail : 1'b0));
      chk("cfg_done", cfg_done, m_done);
      chk("verify_err", verify_err, m_err);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_word_ready && n < 500);
    if (!cfg_word_ready) chk("ready_timeout", cfg_word_ready, 1'b1);
  endtask

  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int gap, input bit mid_start, input bit do_start);
    logic [31:0] w [3];
    int n;
    w[0] = w0; w[1] = w1; w[2] = w2;
    if (do_start) pulse_start();
    for (int i = 0; i < NWORDS; i++) begin
      if (i > 0 && gap > 0) begin
        wait_ready();
        repeat (gap) @(posedge clk);
        #1;
      end
      cfg_word       = w[i];
      cfg_word_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      cfg_word_valid = 1'b0;
      cfg_word       = $urandom;
      if (mid_start && i == 0) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    if (busy) chk("done_timeout", busy, 1'b0);
  endtask

  initial begin
    int s0, b0;
    logic [31:0] r0, r1, r2;

    prog_reset = 1'b1; start = 1'b0; cfg_word = '0; cfg_word_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 prog_reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_ready", cfg_word_ready, 1'b0);
    chk("rst_shift", ccff_shift_en, 1'b0);
    chk("rst_head", ccff_head, 1'b0);
    chk("rst_verr", verify_err, 1'b0);

    // Basic load with minimum latency.
    s0 = shift_cnt; b0 = busy_cnt;
    run_load(32'hDEADBEEF, 32'h01234567, 32'hC0000000, 0, 1'b0, 1'b1);
    chk_int("basic_shifts", shift_cnt - s0, CHAIN_LEN);
    chk_int("basic_busy_cycles", busy_cnt - b0, LOAD_CYCLES);
    chk_chain("basic_chain", {32'hDEADBEEF, 32'h01234567, 2'b11});
    chk("basic_done", cfg_done, 1'b1);
    chk("basic_verr", verify_err, 1'b0);

    // Backpressure gaps between words.
    s0 = shift_cnt;
    run_load(32'hDEADBEEF, 32'h01234567, 32'hC0000000, 10, 1'b0, 1'b1);
    chk_int("gap_shifts", shift_cnt - s0, CHAIN_LEN);
    chk_chain("gap_chain", {32'hDEADBEEF, 32'h01234567, 2'b11});

    // Partial final word: only its top two bits reach the chain.
    s0 = shift_cnt;
    run_load(32'hDEADBEEF, 32'h01234567, 32'hFFFFFFFF, 0, 1'b0, 1'b1);
    chk_int("partial_shifts", shift_cnt - s0, CHAIN_LEN);
    chk_chain("partial_chain", {32'hDEADBEEF, 32'h01234567, 2'b11});

    // Reset at cycle 20 of LOAD.
    pulse_start();
    cfg_word = 32'hA5A5A5A5; cfg_word_valid = 1'b1;
    repeat (19) @(posedge clk);
    #1 prog_reset = 1'b1;
    @(posedge clk); #1 prog_reset = 1'b0; cfg_word_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", cfg_done, 1'b0);
    chk("abort_ready", cfg_word_ready, 1'b0);
    chk("abort_shift", ccff_shift_en, 1'b0);
    s0 = shift_cnt;
    run_load(32'h12345678, 32'h9ABCDEF0, 32'h40000000, 0, 1'b0, 1'b1);
    chk_int("after_abort_shifts", shift_cnt - s0, CHAIN_LEN);
    chk_chain("after_abort_chain", {32'h12345678, 32'h9ABCDEF0, 2'b01});

    // Start in DONE clears cfg_done with the transition into LOAD.
    pulse_start();
    @(negedge clk);
    chk("restart_done_low", cfg_done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    @(posedge clk); #1;
    run_load(32'hCAFEF00D, 32'h0F0F0F0F, 32'h80000000, 0, 1'b0, 1'b0);
    chk_chain("restart_chain", {32'hCAFEF00D, 32'h0F0F0F0F, 2'b10});
    chk("restart_final_done", cfg_done, 1'b1);

    // Start while busy is ignored.
    s0 = shift_cnt;
    run_load(32'h55AA55AA, 32'h33CC33CC, 32'h00000000, 0, 1'b1, 1'b1);
    chk_int("midstart_shifts", shift_cnt - s0, CHAIN_LEN);
    chk_chain("midstart_chain", {32'h55AA55AA, 32'h33CC33CC, 2'b00});

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    // Readback corrupted by one flipped tail bit during the verify pass.
    fork
      run_load(32'hDEADBEEF, 32'h01234567, 32'hC0000000, 0, 1'b0, 1'b1);
      begin
        repeat (100) @(posedge clk);
        #1 tail_flip = 1'b1;
        @(posedge clk); #1 tail_flip = 1'b0;
      end
    join
    chk("verify_flip_err", verify_err, 1'b1);
    chk("verify_flip_done", cfg_done, 1'b0);
`endif

    // Randomized loads.
    for (int it = 0; it < 8; it++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      s0 = shift_cnt;
      run_load(r0, r1, r2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0,
               1'($urandom_range(0, 1)), 1'b1);
      chk_int("rand_shifts", shift_cnt - s0, CHAIN_LEN);
      chk_chain("rand_chain", {r0, r1, r2[31:30]});
      chk("rand_done", cfg_done, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
